mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer that shares one 4:1 data mux among four requesters.
//   - Each requester raises req[i] and presents data on its din slice.
//   - The block grants one requester at a time, drives the mux select and forwards beats
//     over a valid/ready output handshake.
//   - A grant is held for at most MAX_HOLD beats, so no requester can starve the others.
// PARAMETERS
//   DW        8   data width of each requester slice and of dout
//   MAX_HOLD  4   max beats per grant before forced rotation (legal range >= 1)
// PORTS
//   clk         in   1      single clock, rising edge
//   rst_n       in   1      asynchronous, active-low reset
//   req         in   4      request per requester; req[0] maps to mux input a ... req[3] to d
//   din         in   4*DW   requester data; slice i = din[i*DW +: DW]
//   dout_ready  in   1      downstream accepts dout this cycle
//   gnt         out  4      one-hot grant (registered); 0 when idle
//   sel         out  2      mux select {s1,s0} of granted requester (registered)
//   dout        out  DW     din slice selected by sel (combinational mux of registered sel)
//   dout_valid  out  1      (state==GRANT) & req[sel]
//   busy        out  1      state==GRANT
// BEHAVIOUR
//   Reset (async, rst_n=0): all state clears immediately, independent of clk.
//     - state=IDLE, gnt=0, sel=0, ptr=0, cnt=0.
//     - dout_valid=0, busy=0.
//     - An in-flight grant is abandoned; no beat completes during reset.
//   State: ptr[1:0] is the round-robin start point; cnt is $clog2(MAX_HOLD+1) bits.
//   FSM has two states, IDLE and GRANT.
//   IDLE:
//     - If req==0: stay in IDLE.
//     - Else: winner = first i with req[i]=1, scanning ptr, ptr+1, ... (mod 4).
//     - Next edge: gnt=1<<winner, sel=winner, cnt=0, go to GRANT.
//     - Latency: req sampled at edge n gives gnt/sel at edge n+1.
//   GRANT:
//     - Beat = dout_valid & dout_ready; on a beat, cnt increments.
//     - Release if req[sel]=0: no beat that cycle.
//     - Release if a beat occurs with cnt==MAX_HOLD-1: the beat completes, then release.
//     - Otherwise hold. dout_ready low with req held keeps the grant indefinitely;
//       there is no timeout.
//     - On release, at the next edge: state=IDLE, gnt=0, ptr=sel+1 (mod 4, wraps 3->0), cnt=0.
//   Handoff always costs exactly one IDLE cycle, even when only one requester is active.
//   sel and gnt change only on IDLE->GRANT and GRANT->IDLE transitions.
//   - Never change mid-grant.
//   - Requesters other than sel are ignored during GRANT.
//   dout is don't-care (but still equals din[sel]) when dout_valid=0.
//   Simultaneous requests are resolved by ptr order only; there is no fixed priority after reset.
//   A requester must not change its din slice while it is granted, dout_valid=1 and
//   dout_ready=0. The block does not check this.
// TESTING
//   1 Reset: req=4'b0001, pulse rst_n low mid-GRANT.
//     -> gnt=0, dout_valid=0 during reset with no clk edge needed.
//     -> After release: gnt=4'b0001 one edge later, cnt restarts at 0.
//   2 Fairness: req=4'b1111 held, dout_ready=1, MAX_HOLD=4.
//     -> Grants 0,1,2,3,0 in order, 4 beats each, one IDLE cycle between grants.
//   3 Single requester: req=4'b0100 held.
//     -> gnt=4'b0100, sel=2'b10.
//     -> 4 beats, 1 IDLE cycle, then regranted to 2 (ptr=3 wraps to 2).
//   4 Backpressure: granted 0, dout_ready=0 for 3 cycles after 1 beat.
//     -> dout_valid=1 and dout stable; cnt stays 1; gnt unchanged.
//     -> After dout_ready=1: 3 more beats, then release.
//   5 Early drop: req1 drops after 2 beats, req=4'b1001 pending.
//     -> IDLE with ptr=2, next grant is 3 (then 0), not 0.
//   6 Datapath: din3 slice=8'hA5, others 8'h00, grant on 3.
//     -> dout=8'hA5 and sel=2'b11 in the same cycle gnt=4'b1000.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
//   Round-robin arbiter and sequencer that shares one 4:1 data mux among four
//   requesters. One requester is granted at a time. Its data slice is forwarded
//   over a valid/ready output handshake. A grant lasts at most MAX_HOLD beats,
//   and then the grant rotates to the next requester.
//
// Handshake: a beat is transferred on a rising clk edge where
//   dout_valid & dout_ready are both 1. dout_valid never depends on dout_ready.
//   While dout_valid=1 and dout_ready=0, the granted requester keeps its din
//   slice stable.
//
// Ports
//   clk         in   1      single clock, rising edge
//   rst_n       in   1      asynchronous, active-low reset
//   req         in   4      request per requester (req[0] = mux input a ... req[3] = d)
//   din         in   4*DW   requester data, slice i = din[i*DW +: DW]
//   dout_ready  in   1      downstream accepts dout this cycle
//   gnt         out  4      one-hot registered grant, 0 when idle
//   sel         out  2      registered mux select of the granted requester
//   dout        out  DW     din slice chosen by sel
//   dout_valid  out  1      GRANT state and the granted requester still requests
//   busy        out  1      FSM state debug view (1 = GRANT, 0 = IDLE)
// -----------------------------------------------------------------------------
module mux4_rr_arbiter #(
   parameter int DW       = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [3:0]      req,
   input  logic [4*DW-1:0] din,
   input  logic            dout_ready,
   output logic [3:0]      gnt,
   output logic [1:0]      sel,
   output logic [DW-1:0]   dout,
   output logic            dout_valid,
   output logic            busy
);

   localparam int CW = $clog2(MAX_HOLD + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t        state, state_nxt;
   logic [3:0]    gnt_nxt;
   logic [1:0]    sel_nxt;
   logic [1:0]    ptr, ptr_nxt;
   logic [CW-1:0] cnt, cnt_nxt;

   logic [7:0]    req_dbl;
   logic [3:0]    req_rot;
   logic [1:0]    win_off;
   logic [1:0]    win;
   logic          beat;

   // Rotate req so that bit 0 is the requester at ptr. The lowest set bit of
   // the rotated vector is then the round-robin winner, taken as an offset
   // from ptr.
   always_comb begin
      req_dbl = {req, req} >> ptr;
      req_rot = req_dbl[3:0];
      win_off = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (req_rot[k]) win_off = 2'(k);
      end
      win = ptr + win_off;
   end

   assign busy       = (state == GRANT);
   assign dout_valid = (state == GRANT) & req[sel];
   assign dout       = din[32'(sel) * DW +: DW];
   assign beat       = dout_valid & dout_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         gnt   <= 4'b0000;
         sel   <= 2'd0;
         ptr   <= 2'd0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         gnt   <= gnt_nxt;
         sel   <= sel_nxt;
         ptr   <= ptr_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      sel_nxt   = sel;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      unique case (state)
         IDLE: begin
            if (|req) begin
               state_nxt = GRANT;
               gnt_nxt   = 4'b0001 << win;
               sel_nxt   = win;
               cnt_nxt   = '0;
            end
         end
         GRANT: begin
            // A dropped request releases without a beat. The last allowed
            // beat completes, and the grant is released on the same edge.
            if (!req[sel] || (beat && cnt == CNT_LAST)) begin
               state_nxt = IDLE;
               gnt_nxt   = 4'b0000;
               ptr_nxt   = sel + 2'd1;
               cnt_nxt   = '0;
            end else if (beat) begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux4_rr_arbiter
//   Directed bench for mux4_rr_arbiter (DW=8, MAX_HOLD=4). Each expected beat
//   {sel, dout} is pushed to exp_q when the step that produces it is set up.
//   A negedge monitor pops exp_q for every beat the DUT presents. Grant,
//   select and handshake outputs are checked directly at points #1 after the
//   active edge.
// -----------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

   localparam int DW       = 8;
   localparam int MAX_HOLD = 4;

   logic            clk;
   logic            rst_n;
   logic [3:0]      req;
   logic [4*DW-1:0] din;
   logic            dout_ready;
   logic [3:0]      gnt;
   logic [1:0]      sel;
   logic [DW-1:0]   dout;
   logic            dout_valid;
   logic            busy;

   logic [DW-1:0]   d [4];
   logic [DW+1:0]   exp_q [$];
   int              n_checks;
   int              n_fail;

   mux4_rr_arbiter #(.DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .din        (din),
      .dout_ready (dout_ready),
      .gnt        (gnt),
      .sel        (sel),
      .dout       (dout),
      .dout_valid (dout_valid),
      .busy       (busy)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver helpers ----------------
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_din();
      din = {d[3], d[2], d[1], d[0]};
   endtask

   task automatic push_beats(input int w, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({2'(w), d[w]});
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   // Inputs are stable at the negedge, so valid & ready seen here is the beat
   // that completes on the next rising edge.
   always @(negedge clk) begin
      if (rst_n && dout_valid && dout_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", {22'd0, sel, dout}, 32'h3ff);
         end else begin
            logic [DW+1:0] e;
            e = exp_q.pop_front();
            check("beat", {22'd0, sel, dout}, {22'd0, e});
         end
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      n_checks   = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      req        = 4'b0000;
      dout_ready = 1'b0;
      for (int i = 0; i < 4; i++) d[i] = {2'(i), 6'($urandom_range(0, 63))};
      set_din();

      // Reset state
      #12;
      check("rst_gnt",   32'(gnt), 32'h0);
      check("rst_sel",   32'(sel), 32'h0);
      check("rst_valid", 32'(dout_valid), 32'h0);
      check("rst_busy",  32'(busy), 32'h0);

      // Test 1: async reset mid-GRANT, then regrant with cnt restarted
      cycle();
      rst_n = 1'b1;
      req   = 4'b0001;
      cycle();
      check("t1_gnt",   32'(gnt), 32'h1);
      check("t1_valid", 32'(dout_valid), 32'h1);
      #1 rst_n = 1'b0;
      #1;
      check("t1_async_gnt",   32'(gnt), 32'h0);
      check("t1_async_valid", 32'(dout_valid), 32'h0);
      check("t1_async_busy",  32'(busy), 32'h0);
      cycle();
      rst_n = 1'b1;
      cycle();
      check("t1_regnt", 32'(gnt), 32'h1);
      dout_ready = 1'b1;
      push_beats(0, 4);
      repeat (3) cycle();
      check("t1_hold3", 32'(gnt), 32'h1);
      cycle();
      check("t1_release", 32'(gnt), 32'h0);
      req = 4'b0000;

      // Test 2: fairness with all four requesting, starting from ptr=0
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         push_beats(g % 4, 4);
         cycle();
         check("t2_gnt", 32'(gnt), 32'(4'b0001 << (g % 4)));
         check("t2_sel", 32'(sel), 32'(g % 4));
         repeat (3) cycle();
         check("t2_hold", 32'(gnt), 32'(4'b0001 << (g % 4)));
         cycle();
         check("t2_idle", 32'(busy), 32'h0);
      end
      req = 4'b0000;

      // Test 3: single requester 2 is regranted after one IDLE cycle
      req = 4'b0100;
      for (int r = 0; r < 2; r++) begin
         push_beats(2, 4);
         cycle();
         check("t3_gnt", 32'(gnt), 32'h4);
         check("t3_sel", 32'(sel), 32'h2);
         repeat (4) cycle();
         check("t3_idle", 32'(busy), 32'h0);
      end
      req = 4'b0000;

      // Test 4: backpressure on requester 0 after one beat
      dout_ready = 1'b0;
      req = 4'b0001;
      cycle();
      check("t4_gnt", 32'(gnt), 32'h1);
      push_beats(0, 1);
      dout_ready = 1'b1;
      cycle();
      dout_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("t4_valid", 32'(dout_valid), 32'h1);
         check("t4_dout",  32'(dout), 32'(d[0]));
         check("t4_gnt_bp", 32'(gnt), 32'h1);
      end
      dout_ready = 1'b1;
      push_beats(0, 3);
      repeat (2) cycle();
      check("t4_hold", 32'(gnt), 32'h1);
      cycle();
      check("t4_release", 32'(gnt), 32'h0);
      req = 4'b0000;

      // Test 5: requester 1 drops after two beats, pending 3 then 0
      req = 4'b1011;
      cycle();
      check("t5_gnt1", 32'(gnt), 32'h2);
      push_beats(1, 2);
      repeat (2) cycle();
      check("t5_hold", 32'(gnt), 32'h2);
      req = 4'b1001;
      #1;
      check("t5_drop_valid", 32'(dout_valid), 32'h0);
      cycle();
      check("t5_idle", 32'(gnt), 32'h0);
      push_beats(3, 4);
      cycle();
      check("t5_gnt3", 32'(gnt), 32'h8);
      repeat (4) cycle();
      check("t5_idle3", 32'(gnt), 32'h0);
      cycle();
      check("t5_gnt0", 32'(gnt), 32'h1);
      req = 4'b0000;
      cycle();
      check("t5_idle_end", 32'(busy), 32'h0);

      // Test 6: datapath from requester 3
      d[0] = 8'h00; d[1] = 8'h00; d[2] = 8'h00; d[3] = 8'hA5;
      set_din();
      dout_ready = 1'b0;
      req = 4'b1000;
      cycle();
      check("t6_gnt",  32'(gnt), 32'h8);
      check("t6_sel",  32'(sel), 32'h3);
      check("t6_dout", 32'(dout), 32'hA5);
      req = 4'b0000;
      cycle();
      check("t6_idle", 32'(busy), 32'h0);

      // Every expected beat must have been consumed.
      check("sb_drain", 32'(exp_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
